fb_ctrl: RTL and testbench
==========================

FB_CTRL -- requirements
Module: fb_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- FB_WIDTH, 214, pixels per line.
- FB_HEIGHT, 160, lines.
- FB_DEPTH, FB_WIDTH*FB_HEIGHT (34240), pixel count.
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  system clock, 50MHz
- rst_async_n  in  1  async active-low reset
- vga_addr  in  16  linear pixel address from the VGA scan-out block
- vga_pixel  out  3  RGB pixel for vga_addr
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_x  in  8  pixel column
- cpu_y  in  8  pixel row
- cpu_wdata  in  3  write pixel RGB
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  out-of-range flag, valid with cpu_ack
- cpu_rdata  out  3  read data, valid with cpu_ack
- clr_start  in  1  start whole-screen fill
- clr_colour  in  3  fill RGB, sampled with clr_start
- clr_busy  out  1  fill in progress

Function
REQ-004 Storage SHALL be FB_DEPTH x 3-bit words, with one write port and two synchronous read ports (VGA, CPU).
REQ-005 The VGA read port SHALL drive vga_pixel = mem[vga_addr] one cycle after vga_addr, every cycle, independent of FSM state.
REQ-006 A vga_addr >= FB_DEPTH SHALL yield vga_pixel = 0 on the following cycle.
REQ-007 A VGA read and a write to the same address in the same cycle SHALL return the old data.
REQ-008 The FSM SHALL have states IDLE, CALC, ACCESS, RESP and CLEAR.
REQ-009 In IDLE with clr_start=1, the FSM SHALL latch clr_colour, zero the fill counter and go to CLEAR; this SHALL take priority over a simultaneous cpu_req.
REQ-010 In IDLE with cpu_req=1 and clr_start=0, the FSM SHALL latch cpu_we/x/y/wdata and go to CALC.
REQ-011 In CALC the FSM SHALL register lin = y*214 + x using shift-add (y<<7 + y<<6 + y<<4 + y<<2 + y<<1), computed in 16 bits, and register range_err = (x>=FB_WIDTH)|(y>=FB_HEIGHT); it SHALL then go to ACCESS.
REQ-012 In ACCESS, if range_err=0, the FSM SHALL write mem[lin] when we=1 or issue a read of lin when we=0; if range_err=1 it SHALL do nothing; it SHALL then go to RESP.
REQ-013 In RESP the block SHALL pulse cpu_ack=1 for exactly one cycle, with cpu_err=range_err and cpu_rdata = read data (0 on write or error), then return to IDLE.
REQ-014 CPU latency SHALL be 3 cycles: cpu_req sampled in IDLE at edge N gives cpu_ack high after edge N+3.
REQ-015 cpu_req still high in IDLE after RESP SHALL be treated as a new request; the requester drops cpu_req on the cycle of cpu_ack.
REQ-016 In CLEAR the block SHALL write the latched colour to mem[cnt] each cycle for cnt = 0..FB_DEPTH-1, then return to IDLE; this takes FB_DEPTH cycles.
REQ-017 clr_busy SHALL be 1 exactly while in CLEAR.
REQ-018 clr_start while busy SHALL be ignored.
REQ-019 cpu_req while busy SHALL stay pending, with no ack, until IDLE.
REQ-020 cpu_ack and cpu_err SHALL be 0 in every state except RESP.
REQ-021 cpu_rdata SHALL hold its last value outside RESP.

Reset
REQ-022 While rst_async_n=0, the block SHALL force state=IDLE, vga_pixel=0, cpu_ack=0, cpu_err=0, cpu_rdata=0, clr_busy=0 and the fill counter to 0, asynchronously.
REQ-023 Memory contents SHALL NOT be reset.
REQ-024 Reset during CLEAR SHALL abort the fill and leave a partially filled memory; reset during a CPU access SHALL drop the access with no ack.

Verification
REQ-025 Write x=5, y=2, wdata=3'b101 -> cpu_ack 3 cycles after req with err=0; vga_addr=433 -> vga_pixel=3'b101 next cycle.
REQ-026 Read x=213, y=159 after writing 3'b011 there -> cpu_rdata=3'b011 with cpu_ack, err=0 (lin=34239).
REQ-027 Write x=214, y=0, then x=0, y=160 -> cpu_ack with cpu_err=1 each time; memory unchanged (check addr 214 and 0).
REQ-028 clr_start with colour 3'b110 -> clr_busy high for exactly 34240 cycles; a cpu_req raised mid-fill is acked only after clr_busy falls; vga_addr 0 and 34239 -> 3'b110.
REQ-029 clr_start and cpu_req in the same IDLE cycle -> CLEAR first, then the CPU access; vga_addr=40000 -> vga_pixel=0.
REQ-030 Assert rst_async_n=0 mid-fill at cnt=1000 -> all outputs 0 immediately; addr 999 holds the fill colour; addr 1001 holds its prior value.

Source files
------------

// File: rtl/fb_ctrl.sv
// Frame-buffer controller: a 214x160 3-bit pixel store with a free-running VGA read
// port, and a CPU port that is sequenced by a small FSM. The FSM also runs a whole-screen fill.
module fb_ctrl #(
  parameter int FB_WIDTH  = 214,
  parameter int FB_HEIGHT = 160,
  parameter int FB_DEPTH  = FB_WIDTH * FB_HEIGHT
) (
  input  logic        clk,
  input  logic        rst_async_n,
  input  logic [15:0] vga_addr,
  output logic [2:0]  vga_pixel,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_x,
  input  logic [7:0]  cpu_y,
  input  logic [2:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [2:0]  cpu_rdata,
  input  logic        clr_start,
  input  logic [2:0]  clr_colour,
  output logic        clr_busy
);

  localparam logic [15:0] DEPTH_W  = 16'(FB_DEPTH);
  localparam logic [7:0]  WIDTH_W  = 8'(FB_WIDTH);
  localparam logic [7:0]  HEIGHT_W = 8'(FB_HEIGHT);

  typedef enum logic [2:0] {IDLE, CALC, ACCESS, RESP, CLEAR} state_t;

  state_t      state;
  logic [2:0]  mem [FB_DEPTH];
  logic        we_q;
  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic [2:0]  wdata_q;
  logic [15:0] lin;
  logic        range_err;
  logic [2:0]  colour_q;
  logic [15:0] cnt;
  logic [2:0]  rd_q;
  logic [15:0] y16;

  logic        mem_we;
  logic [15:0] mem_waddr;
  logic [2:0]  mem_wdata;

  assign y16 = {8'b0, y_q};

  // Single write port shared between the fill engine and CPU writes.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    mem_we    = 1'b0;
    mem_waddr = lin;
    mem_wdata = wdata_q;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_wdata = colour_q;
    end else if (state == ACCESS && we_q && !range_err) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the pixel array is deliberately left without a reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state == ACCESS && !we_q && !range_err) rd_q <= mem[lin];
  end

  // Scan-out port; a same-cycle write is not visible until the next read (old data).
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      vga_pixel <= '0;
    end else if (vga_addr < DEPTH_W) begin
      vga_pixel <= mem[vga_addr];
    end else begin
      vga_pixel <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples pre-edge values regardless of statement order.
      state     <= IDLE;
      cnt       <= '0;
      clr_busy  <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      we_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      wdata_q   <= '0;
      lin       <= '0;
      range_err <= 1'b0;
      colour_q  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            colour_q <= clr_colour;
            cnt      <= '0;
            clr_busy <= 1'b1;
            state    <= CLEAR;
          end else if (cpu_req) begin
            we_q    <= cpu_we;
            x_q     <= cpu_x;
            y_q     <= cpu_y;
            wdata_q <= cpu_wdata;
            state   <= CALC;
          end
        end
        CALC: begin
          // y*214 = y*(128+64+16+4+2)
          lin       <= (y16 << 7) + (y16 << 6) + (y16 << 4) + (y16 << 2) + (y16 << 1)
                       + {8'b0, x_q};
          range_err <= (x_q >= WIDTH_W) | (y_q >= HEIGHT_W);
          state     <= ACCESS;
        end
        ACCESS: state <= RESP;
        RESP: begin
          cpu_ack   <= 1'b1;
          cpu_err   <= range_err;
          cpu_rdata <= (we_q || range_err) ? 3'b000 : rd_q;
          state     <= IDLE;
        end
        CLEAR: begin
          if (cnt == DEPTH_W - 16'd1) begin
            clr_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_ctrl.sv
// Directed bench for fb_ctrl: CPU accesses, range errors, fills, clear/CPU arbitration
// and reset mid-fill, checked through expected-value queues.
module tb_fb_ctrl;

  logic        clk = 1'b0;
  logic        rst_async_n = 1'b0;
  logic [15:0] vga_addr = '0;
  logic [2:0]  vga_pixel;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_x = '0;
  logic [7:0]  cpu_y = '0;
  logic [2:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic        cpu_err;
  logic [2:0]  cpu_rdata;
  logic        clr_start = 1'b0;
  logic [2:0]  clr_colour = '0;
  logic        clr_busy;

  fb_ctrl dut (
    .clk(clk), .rst_async_n(rst_async_n),
    .vga_addr(vga_addr), .vga_pixel(vga_pixel),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_x(cpu_x), .cpu_y(cpu_y),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_colour(clr_colour), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       err;
    logic [2:0] data;
  } cpu_exp_t;

  cpu_exp_t   cpu_q[$];
  logic [2:0] vga_q[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vga_check(input logic [15:0] addr, input logic [2:0] exp, input string tag);
    logic [2:0] e;
    vga_q.push_back(exp);
    vga_addr = addr;
    tick();
    e = vga_q.pop_front();
    check(tag, 32'(vga_pixel), 32'(e));
  endtask

  task automatic start_op(input logic we, input logic [7:0] x, input logic [7:0] y,
                          input logic [2:0] wd, input logic exp_err, input logic [2:0] exp_rd);
    cpu_q.push_back('{exp_err, exp_rd});
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_x     = x;
    cpu_y     = y;
    cpu_wdata = wd;
  endtask

  // lat_exp < 0 skips the latency check (request held across a fill).
  task automatic finish_op(input string tag, input int lat_exp);
    cpu_exp_t e;
    int cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!cpu_ack && cyc < 40000);
    cpu_req = 1'b0;
    e = cpu_q.pop_front();
    check({tag, "_ack"}, 32'(cpu_ack), 32'd1);
    check({tag, "_err"}, 32'(cpu_err), 32'(e.err));
    check({tag, "_rdata"}, 32'(cpu_rdata), 32'(e.data));
    // cyc counts the sampling edge itself, so latency after sampling is cyc-1.
    if (lat_exp >= 0) check({tag, "_lat"}, 32'(cyc - 1), 32'(lat_exp));
    tick();
    check({tag, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
  endtask

  task automatic cpu_op(input logic we, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] wd, input logic exp_err, input logic [2:0] exp_rd,
                        input string tag);
    start_op(we, x, y, wd, exp_err, exp_rd);
    finish_op(tag, 3);
  endtask

  initial begin
    int n;

    // Reset state
    tick();
    tick();
    check("rst_vga", 32'(vga_pixel), 32'd0);
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_err", 32'(cpu_err), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_busy", 32'(clr_busy), 32'd0);
    rst_async_n = 1'b1;
    tick();

    // Basic write then scan-out
    cpu_op(1'b1, 8'd5, 8'd2, 3'b101, 1'b0, 3'b000, "wr_5_2");
    vga_check(16'd433, 3'b101, "vga_433");

    // Last pixel write/read
    cpu_op(1'b1, 8'd213, 8'd159, 3'b011, 1'b0, 3'b000, "wr_213_159");
    cpu_op(1'b0, 8'd213, 8'd159, 3'b000, 1'b0, 3'b011, "rd_213_159");
    vga_check(16'd34239, 3'b011, "vga_34239");

    // Out-of-range writes leave memory untouched
    cpu_op(1'b1, 8'd0, 8'd1, 3'b111, 1'b0, 3'b000, "wr_0_1");
    cpu_op(1'b1, 8'd0, 8'd0, 3'b100, 1'b0, 3'b000, "wr_0_0");
    cpu_op(1'b1, 8'd214, 8'd0, 3'b010, 1'b1, 3'b000, "wr_x_oob");
    cpu_op(1'b1, 8'd0, 8'd160, 3'b010, 1'b1, 3'b000, "wr_y_oob");
    cpu_op(1'b0, 8'd255, 8'd255, 3'b000, 1'b1, 3'b000, "rd_oob");
    vga_check(16'd214, 3'b111, "vga_214_kept");
    vga_check(16'd0, 3'b100, "vga_0_kept");
    vga_check(16'd40000, 3'b000, "vga_oob");

    // Full fill; CPU request and a second clr_start raised mid-fill
    clr_colour = 3'b110;
    clr_start  = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (clr_busy && n < 40000) begin
      n++;
      if (n == 100) start_op(1'b0, 8'd0, 8'd0, 3'b000, 1'b0, 3'b110);
      if (n == 200) begin
        clr_start  = 1'b1;
        clr_colour = 3'b011;
      end
      if (n == 201) clr_start = 1'b0;
      tick();
    end
    check("fill_busy_len", 32'(n), 32'd34240);
    finish_op("rd_after_fill", -1);
    check("fill_busy_low", 32'(clr_busy), 32'd0);
    vga_check(16'd0, 3'b110, "fill_vga_0");
    vga_check(16'd34239, 3'b110, "fill_vga_last");

    // clr_start and cpu_req together: fill wins, read then sees new colour
    clr_colour = 3'b010;
    clr_start  = 1'b1;
    start_op(1'b0, 8'd1, 8'd0, 3'b000, 1'b0, 3'b010);
    tick();
    clr_start = 1'b0;
    check("prio_busy", 32'(clr_busy), 32'd1);
    finish_op("prio_rd", -1);
    check("prio_busy_low", 32'(clr_busy), 32'd0);
    vga_check(16'd40000, 3'b000, "prio_vga_oob");

    // Reset mid-fill at cnt=1000
    vga_addr   = 16'd1;
    clr_colour = 3'b001;
    clr_start  = 1'b1;
    tick();
    clr_start = 1'b0;
    check("abort_busy", 32'(clr_busy), 32'd1);
    check("abort_vga_pre", 32'(vga_pixel), 32'd2);
    repeat (1000) @(posedge clk);
    #1;
    rst_async_n = 1'b0;
    #1;
    check("abort_vga", 32'(vga_pixel), 32'd0);
    check("abort_busy0", 32'(clr_busy), 32'd0);
    check("abort_ack", 32'(cpu_ack), 32'd0);
    check("abort_err", 32'(cpu_err), 32'd0);
    check("abort_rdata", 32'(cpu_rdata), 32'd0);
    tick();
    rst_async_n = 1'b1;
    tick();
    vga_check(16'd999, 3'b001, "abort_vga_999");
    vga_check(16'd1000, 3'b010, "abort_vga_1000");
    vga_check(16'd1001, 3'b010, "abort_vga_1001");
    vga_check(16'd0, 3'b001, "abort_vga_0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
